// File: rtl/seg7_probe_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_probe_display : probe-word selector with freeze snapshot, auto-cycle and
// seven-segment decode of a DIGITS-nibble window.            Rev 1.0
// ---------------------------------------------------------------------------
module seg7_probe_display #(
  parameter int          CHANNELS        = 8,
  parameter int          SEL_WIDTH       = 4,
  parameter int          PROBE_WIDTH     = 32,
  parameter int          DIGITS          = 4,
  parameter int          WIN_WIDTH       = 1,
  parameter logic [31:0] FILL            = 32'hBADDF00D,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          CYCLE_TICKS     = 50000000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS*PROBE_WIDTH-1:0] probes,
  input  logic [SEL_WIDTH-1:0]            sel,
  input  logic [WIN_WIDTH-1:0]            window,
  input  logic                            freeze_btn,
  input  logic                            auto_mode,
  output logic [4*DIGITS-1:0]             hex_out,
  output logic [8*DIGITS-1:0]             seg,
  output logic                            frozen,
  output logic [SEL_WIDTH-1:0]            chan_idx
);

  localparam int HEX_W = 4 * DIGITS;
  localparam int SPAN  = (1 << WIN_WIDTH) * HEX_W;
  localparam int WIDE  = (SPAN > PROBE_WIDTH) ? SPAN : PROBE_WIDTH;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TK_W  = $clog2(CYCLE_TICKS + 1);
  localparam logic [PROBE_WIDTH-1:0] FILL_W = PROBE_WIDTH'(FILL);

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg7 = 7'h3F;  4'h1: hex_to_seg7 = 7'h06;
      4'h2: hex_to_seg7 = 7'h5B;  4'h3: hex_to_seg7 = 7'h4F;
      4'h4: hex_to_seg7 = 7'h66;  4'h5: hex_to_seg7 = 7'h6D;
      4'h6: hex_to_seg7 = 7'h7D;  4'h7: hex_to_seg7 = 7'h07;
      4'h8: hex_to_seg7 = 7'h7F;  4'h9: hex_to_seg7 = 7'h6F;
      4'hA: hex_to_seg7 = 7'h77;  4'hB: hex_to_seg7 = 7'h7C;
      4'hC: hex_to_seg7 = 7'h39;  4'hD: hex_to_seg7 = 7'h5E;
      4'hE: hex_to_seg7 = 7'h79;  default: hex_to_seg7 = 7'h71;
    endcase
  endfunction

  logic [PROBE_WIDTH-1:0] live [CHANNELS];
  logic [PROBE_WIDTH-1:0] snap [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign live[c] = probes[c*PROBE_WIDTH +: PROBE_WIDTH];
  end

  // Button path: two-flop synchroniser, then a level is accepted only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreeing with the current one.
  logic            sync_a, sync_b, db_level, db_prev, press;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_a  <= freeze_btn;
      sync_b  <= sync_a;
      db_prev <= db_level;
      if (sync_b != db_level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= sync_b;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = db_level & ~db_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frozen <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) snap[c] <= '0;
    end else if (press) begin
      frozen <= ~frozen;
      if (!frozen) begin
        for (int c = 0; c < CHANNELS; c++) snap[c] <= live[c];
      end
    end
  end

  logic                 auto_q;
  logic [SEL_WIDTH-1:0] auto_idx, sel_clamped, eff;
  logic [TK_W-1:0]      tick;

  assign sel_clamped = (int'(sel) < CHANNELS) ? sel : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_q   <= 1'b0;
      auto_idx <= '0;
      tick     <= '0;
    end else begin
      auto_q <= auto_mode;
      if (auto_mode && !auto_q) begin
        auto_idx <= sel_clamped;
        tick     <= '0;
      end else if (auto_mode) begin
        if (tick == TK_W'(CYCLE_TICKS - 1)) begin
          tick     <= '0;
          auto_idx <= (auto_idx == SEL_WIDTH'(CHANNELS - 1)) ? '0 : auto_idx + SEL_WIDTH'(1);
        end else begin
          tick <= tick + TK_W'(1);
        end
      end
    end
  end

  logic [PROBE_WIDTH-1:0] word;
  logic [WIDE-1:0]        wide;
  logic [HEX_W-1:0]       win_bits;

  // On the auto_mode rising cycle the index register is not loaded yet, so the
  // clamped sel is forwarded to keep the display in step with the index.
  always_comb begin
    eff  = auto_mode ? (auto_q ? auto_idx : sel_clamped) : sel;
    word = FILL_W;
    for (int c = 0; c < CHANNELS; c++) begin
      if (eff == SEL_WIDTH'(c)) word = frozen ? snap[c] : live[c];
    end
    wide     = WIDE'(word);
    win_bits = HEX_W'(wide >> (int'(window) * HEX_W));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hex_out  <= '0;
      chan_idx <= '0;
    end else begin
      hex_out  <= win_bits;
      chan_idx <= eff;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign seg[8*d +: 7] = hex_to_seg7(hex_out[4*d +: 4]);
    if (d == 0) begin : g_frz
      assign seg[8*d+7] = frozen;
    end else if (d == 1) begin : g_auto
      assign seg[8*d+7] = auto_q;
    end else begin : g_off
      assign seg[8*d+7] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_probe_display.sv
`default_nettype none
// Randomised + directed bench for seg7_probe_display with a queue scoreboard
// fed by a behavioural model of the display rules.
module tb_seg7_probe_display;

  localparam int CH = 6;
  localparam int DB = 4;
  localparam int CT = 10;

  localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clock = 1'b0;
  logic          reset;
  logic [CH*32-1:0] probes;
  logic [31:0]   pw [CH];
  logic [3:0]    sel;
  logic [0:0]    window;
  logic          freeze_btn, auto_mode;
  logic [15:0]   hex_out;
  logic [31:0]   seg;
  logic          frozen;
  logic [3:0]    chan_idx;

  int checks = 0;
  int failures = 0;

  for (genvar c = 0; c < CH; c++) begin : g_pw
    assign probes[c*32 +: 32] = pw[c];
  end

  seg7_probe_display #(
    .CHANNELS(CH), .SEL_WIDTH(4), .PROBE_WIDTH(32), .DIGITS(4), .WIN_WIDTH(1),
    .FILL(32'hBADDF00D), .DEBOUNCE_CYCLES(DB), .CYCLE_TICKS(CT)
  ) dut (
    .clock(clock), .reset(reset), .probes(probes), .sel(sel), .window(window),
    .freeze_btn(freeze_btn), .auto_mode(auto_mode), .hex_out(hex_out), .seg(seg),
    .frozen(frozen), .chan_idx(chan_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  chan;
    logic        frz;
    logic [31:0] seg;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state is kept as plain facts about the history.
  logic [31:0] m_snap [CH];
  bit  m_s1, m_s2, m_db, m_dbp, m_frz, m_ap;
  int  m_run, m_aidx, m_tick;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_frz = 0; m_ap = 0;
    m_run = 0; m_aidx = 0; m_tick = 0;
    for (int c = 0; c < CH; c++) m_snap[c] = 32'h0;
  endtask

  task automatic model_step();
    int eff;
    logic [31:0] word;
    exp_t e;
    if (auto_mode) eff = m_ap ? m_aidx : ((int'(sel) < CH) ? int'(sel) : 0);
    else           eff = int'(sel);
    if (eff >= CH) word = 32'hBADDF00D;
    else           word = m_frz ? m_snap[eff] : pw[eff];
    e.hex  = 16'(word >> (int'(window) * 16));
    e.chan = 4'(eff);
    if (m_db && !m_dbp) begin
      if (!m_frz) for (int c = 0; c < CH; c++) m_snap[c] = pw[c];
      m_frz = !m_frz;
    end
    m_dbp = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DB) begin m_db = m_s2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = freeze_btn;
    if (auto_mode && !m_ap) begin
      m_aidx = (int'(sel) < CH) ? int'(sel) : 0;
      m_tick = 0;
    end else if (auto_mode) begin
      if (m_tick == CT - 1) begin m_tick = 0; m_aidx = (m_aidx + 1) % CH; end
      else m_tick++;
    end
    m_ap = auto_mode;
    e.frz = m_frz;
    for (int d = 0; d < 4; d++) e.seg[8*d +: 7] = SEG_TBL[e.hex[4*d +: 4]];
    e.seg[7]  = m_frz;
    e.seg[15] = auto_mode;
    e.seg[23] = 1'b0;
    e.seg[31] = 1'b0;
    sb.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_hex", 32'(hex_out), 32'(e.hex));
        chk("sb_chan", 32'(chan_idx), 32'(e.chan));
        chk("sb_frozen", 32'(frozen), 32'(e.frz));
        chk("sb_seg", seg, e.seg);
      end
    end
  end

  int btn_left;

  initial begin : driver
    reset = 1'b0; sel = 0; window = 0; freeze_btn = 0; auto_mode = 0;
    for (int c = 0; c < CH; c++) pw[c] = $urandom;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_frozen", 32'(frozen), 32'h0);
    chk("rst_chan", 32'(chan_idx), 32'h0);
    reset = 1'b1;

    pw[3] = 32'h12345678; sel = 3; window = 0; step();
    chk("man_lo", 32'(hex_out), 32'h5678);
    chk("man_chan", 32'(chan_idx), 32'h3);
    window = 1; step();
    chk("man_hi", 32'(hex_out), 32'h1234);
    sel = 7; window = 0; step();
    chk("fill_lo", 32'(hex_out), 32'hF00D);
    window = 1; step();
    chk("fill_hi", 32'(hex_out), 32'hBADD);
    window = 0;

    freeze_btn = 1; repeat (3) step();
    freeze_btn = 0; repeat (10) step();
    chk("glitch_frozen", 32'(frozen), 32'h0);
    freeze_btn = 1; repeat (6) step();
    chk("press_early", 32'(frozen), 32'h0);
    step();
    chk("press_exact", 32'(frozen), 32'h1);
    repeat (3) step();
    freeze_btn = 0; repeat (10) step();
    chk("release_hold", 32'(frozen), 32'h1);
    freeze_btn = 1; repeat (10) step();
    chk("press2", 32'(frozen), 32'h0);
    freeze_btn = 0; repeat (10) step();

    pw[2] = 32'hAAAA5555; sel = 2; step();
    freeze_btn = 1; repeat (10) step();
    chk("frz_on", 32'(frozen), 32'h1);
    freeze_btn = 0; repeat (10) step();
    pw[2] = 32'h0; step();
    chk("frz_hold", 32'(hex_out), 32'h5555);
    freeze_btn = 1; repeat (7) step();
    chk("unfrz", 32'(frozen), 32'h0);
    step();
    chk("unfrz_live", 32'(hex_out), 32'h0000);
    repeat (2) step();
    freeze_btn = 0; repeat (10) step();

    sel = 4; auto_mode = 1; step();
    chk("auto_0", 32'(chan_idx), 32'h4);
    for (int k = 2; k <= 32; k++) begin
      sel = 4'($urandom);
      step();
      if (k == 11) chk("auto_hold", 32'(chan_idx), 32'h4);
      if (k == 12) chk("auto_1", 32'(chan_idx), 32'h5);
      if (k == 22) chk("auto_wrap", 32'(chan_idx), 32'h0);
      if (k == 32) chk("auto_3", 32'(chan_idx), 32'h1);
    end
    auto_mode = 0; sel = 2; step();
    chk("auto_off", 32'(chan_idx), 32'h2);

    btn_left = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pw[$urandom_range(0, CH-1)] = $urandom;
      sel = 4'($urandom_range(0, 8));
      window = 1'($urandom);
      if (btn_left == 0) begin
        freeze_btn = ~freeze_btn;
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      if ($urandom_range(0, 39) == 0) auto_mode = ~auto_mode;
      step();
    end

    auto_mode = 1; freeze_btn = 0; repeat (10) step();
    if (!m_frz) begin freeze_btn = 1; repeat (10) step(); end
    chk("pre_rst_frozen", 32'(frozen), 32'h1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("arst_hex", 32'(hex_out), 32'h0);
    chk("arst_frozen", 32'(frozen), 32'h0);
    chk("arst_chan", 32'(chan_idx), 32'h0);
    model_reset();
    sb.delete();

    freeze_btn = 1; auto_mode = 0; sel = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) step();
    chk("held_early", 32'(frozen), 32'h0);
    step();
    chk("held_frozen", 32'(frozen), 32'h1);
    chk("held_seg7", 32'(seg[7]), 32'h1);
    repeat (3) step();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
